atm_auth_frontend: RTL and testbench

Keypad and card-session front end for the ATM controller. It collects hex keypad entries into a 12-bit account number and a 12-bit PIN, and checks them against a small on-chip account table. It counts wrong-PIN attempts and locks accounts, then presents `account_number`, `pin`, `acct_idx` and a level `auth_ok` to the main ATM FSM. The main FSM uses `auth_ok` in place of its card-inserted and valid-PIN conditions, and pulses `session_end` when the customer exits.

---
 rtl/atm_auth_frontend.sv | 225 ++++++++++++++++++++++
 tb/tb_atm_auth_frontend.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/atm_auth_frontend.sv
// Keypad/card-session front end: collects account and PIN digits, checks them
// against a small on-chip table, tracks wrong-PIN attempts and account locks.
module atm_auth_frontend #(
  parameter int NUM_ACCTS   = 3,
  parameter int DIGITS      = 3,
  parameter int MAX_TRIES   = 3,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  card_in,
  input  logic                  key_valid,
  input  logic [4:0]            key_code,
  input  logic                  session_end,
  input  logic                  tbl_we,
  input  logic [1:0]            tbl_addr,
  input  logic [4*DIGITS-1:0]   tbl_acct,
  input  logic [4*DIGITS-1:0]   tbl_pin,
  output logic [4*DIGITS-1:0]   account_number,
  output logic [4*DIGITS-1:0]   pin,
  output logic [1:0]            acct_idx,
  output logic                  auth_ok,
  output logic                  auth_fail,
  output logic [1:0]            fail_code,
  output logic                  card_locked,
  output logic [2:0]            prompt
);
  localparam int EW = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);
  localparam int TW = $clog2(MAX_TRIES + 1);
  localparam int OW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] DIG_MAX    = CW'(DIGITS);
  localparam logic [TW-1:0] TRY_MAX    = TW'(MAX_TRIES);
  // Reload with T-1 so expiry at 0 lands the abort exactly T cycles after entry.
  localparam logic [OW-1:0] TMO_RELOAD = OW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_ACCT = 3'd1, S_ACHK = 3'd2,
    S_PIN  = 3'd3, S_PCHK = 3'd4, S_AUTH = 3'd5
  } state_t;

  state_t                       state_q, state_d;
  logic [EW-1:0]                ebuf_q, ebuf_d;
  logic [CW-1:0]                cnt_q, cnt_d;
  logic [TW-1:0]                tries_q, tries_d, tries_inc;
  logic [OW-1:0]                tmo_q, tmo_d;
  logic [EW-1:0]                acct_q, acct_d, pin_q, pin_d;
  logic [1:0]                   idx_q, idx_d;
  logic                         fail_q, fail_d, locked_q, locked_d, ok_q;
  logic [1:0]                   code_q, code_d;
  logic [2:0]                   prompt_q;
  logic [NUM_ACCTS-1:0]         lock_q, lock_d;
  logic [NUM_ACCTS-1:0][EW-1:0] tbl_acct_q, tbl_acct_d, tbl_pin_q, tbl_pin_d;

  logic       is_digit, is_enter, is_clear, is_cancel, acct_hit;
  logic [1:0] hit_idx;

  assign is_digit  = key_valid && !key_code[4];
  assign is_enter  = key_valid && key_code == 5'h10;
  assign is_clear  = key_valid && key_code == 5'h11;
  assign is_cancel = key_valid && key_code == 5'h12;
  assign tries_inc = tries_q + 1'b1;

  // Parallel compare; scanning high-to-low leaves the lowest matching index.
  always_comb begin
    acct_hit = 1'b0;
    hit_idx  = 2'd0;
    for (int i = NUM_ACCTS - 1; i >= 0; i--) begin
      if (tbl_acct_q[i] == acct_q) begin
        acct_hit = 1'b1;
        hit_idx  = 2'(i);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ebuf_d     = ebuf_q;
    cnt_d      = cnt_q;
    tries_d    = tries_q;
    tmo_d      = tmo_q;
    acct_d     = acct_q;
    pin_d      = pin_q;
    idx_d      = idx_q;
    fail_d     = 1'b0;
    code_d     = code_q;
    locked_d   = 1'b0;
    lock_d     = lock_q;
    tbl_acct_d = tbl_acct_q;
    tbl_pin_d  = tbl_pin_q;
    case (state_q)
      S_IDLE: begin
        ebuf_d  = '0;
        cnt_d   = '0;
        tries_d = '0;
        if (card_in) begin
          state_d = S_ACCT;
          tmo_d   = TMO_RELOAD;
        end
      end
      S_ACCT, S_PIN: begin
        tmo_d = tmo_q - 1'b1;
        if (tmo_q == '0 || is_cancel) begin
          state_d = S_IDLE;
          tmo_d   = '0;
          fail_d  = 1'b1;
          code_d  = 2'd0;
        end else if (key_valid) begin
          tmo_d = TMO_RELOAD;
          if (is_digit && cnt_q != DIG_MAX) begin
            ebuf_d = {ebuf_q[EW-5:0], key_code[3:0]};
            cnt_d  = cnt_q + 1'b1;
          end else if (is_clear) begin
            ebuf_d = '0;
            cnt_d  = '0;
          end else if (is_enter && cnt_q == DIG_MAX) begin
            if (state_q == S_ACCT) begin
              acct_d  = ebuf_q;
              state_d = S_ACHK;
            end else begin
              pin_d   = ebuf_q;
              state_d = S_PCHK;
            end
          end
        end
      end
      S_ACHK: begin
        if (!acct_hit || lock_q[hit_idx]) begin
          state_d = S_IDLE;
          fail_d  = 1'b1;
          code_d  = acct_hit ? 2'd3 : 2'd1;
        end else begin
          idx_d   = hit_idx;
          ebuf_d  = '0;
          cnt_d   = '0;
          tmo_d   = TMO_RELOAD;
          state_d = S_PIN;
        end
      end
      S_PCHK: begin
        if (pin_q == tbl_pin_q[idx_q]) begin
          state_d = S_AUTH;
        end else begin
          tries_d = tries_inc;
          fail_d  = 1'b1;
          code_d  = 2'd2;
          if (tries_inc == TRY_MAX) begin
            lock_d[idx_q] = 1'b1;
            locked_d      = 1'b1;
            state_d       = S_IDLE;
          end else begin
            ebuf_d  = '0;
            cnt_d   = '0;
            tmo_d   = TMO_RELOAD;
            state_d = S_PIN;
          end
        end
      end
      S_AUTH: begin
        if (session_end) begin
          state_d = S_IDLE;
          acct_d  = '0;
          pin_d   = '0;
          idx_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Table writes apply after the check, so a same-cycle unlock beats a lock.
    for (int i = 0; i < NUM_ACCTS; i++) begin
      if (tbl_we && tbl_addr == 2'(i)) begin
        tbl_acct_d[i] = tbl_acct;
        tbl_pin_d[i]  = tbl_pin;
        lock_d[i]     = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ebuf_q     <= '0;
      cnt_q      <= '0;
      tries_q    <= '0;
      tmo_q      <= '0;
      acct_q     <= '0;
      pin_q      <= '0;
      idx_q      <= '0;
      fail_q     <= 1'b0;
      code_q     <= 2'd0;
      locked_q   <= 1'b0;
      ok_q       <= 1'b0;
      prompt_q   <= 3'd0;
      lock_q     <= '0;
      tbl_acct_q <= '0;
      tbl_pin_q  <= '0;
    end else begin
      state_q    <= state_d;
      ebuf_q     <= ebuf_d;
      cnt_q      <= cnt_d;
      tries_q    <= tries_d;
      tmo_q      <= tmo_d;
      acct_q     <= acct_d;
      pin_q      <= pin_d;
      idx_q      <= idx_d;
      fail_q     <= fail_d;
      code_q     <= code_d;
      locked_q   <= locked_d;
      ok_q       <= (state_d == S_AUTH);
      prompt_q   <= state_d;
      lock_q     <= lock_d;
      tbl_acct_q <= tbl_acct_d;
      tbl_pin_q  <= tbl_pin_d;
    end
  end

  assign account_number = acct_q;
  assign pin            = pin_q;
  assign acct_idx       = idx_q;
  assign auth_ok        = ok_q;
  assign auth_fail      = fail_q;
  assign fail_code      = code_q;
  assign card_locked    = locked_q;
  assign prompt         = prompt_q;
endmodule

// File: tb/tb_atm_auth_frontend.sv
// Directed bench for atm_auth_frontend; failure pulses are scoreboarded.
module tb_atm_auth_frontend;
  logic        clk = 1'b0, rst = 1'b1;
  logic        card_in = 1'b0, key_valid = 1'b0, session_end = 1'b0, tbl_we = 1'b0;
  logic [4:0]  key_code = 5'd0;
  logic [1:0]  tbl_addr = 2'd0;
  logic [11:0] tbl_acct = 12'd0, tbl_pin = 12'd0;
  logic [11:0] account_number, pin;
  logic [1:0]  acct_idx, fail_code;
  logic        auth_ok, auth_fail, card_locked;
  logic [2:0]  prompt;

  int n_chk = 0, n_fail = 0;
  logic [2:0] sb_q[$];
  logic [2:0] sb_e;

  localparam logic [4:0] K_ENTER = 5'h10, K_CLEAR = 5'h11, K_CANCEL = 5'h12;

  atm_auth_frontend #(.NUM_ACCTS(3), .DIGITS(3), .MAX_TRIES(3), .TIMEOUT_CYC(10)) dut (
    .clk(clk), .rst(rst), .card_in(card_in), .key_valid(key_valid), .key_code(key_code),
    .session_end(session_end), .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_acct(tbl_acct),
    .tbl_pin(tbl_pin), .account_number(account_number), .pin(pin), .acct_idx(acct_idx),
    .auth_ok(auth_ok), .auth_fail(auth_fail), .fail_code(fail_code),
    .card_locked(card_locked), .prompt(prompt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic key(input logic [4:0] c);
    key_valid = 1'b1;
    key_code  = c;
    tick();
    key_valid = 1'b0;
    key_code  = 5'd0;
  endtask

  task automatic keys3(input logic [11:0] v);
    key({1'b0, v[11:8]});
    key({1'b0, v[7:4]});
    key({1'b0, v[3:0]});
  endtask

  task automatic card();
    card_in = 1'b1;
    tick();
    card_in = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [11:0] ac, input logic [11:0] pn);
    tbl_we = 1'b1; tbl_addr = a; tbl_acct = ac; tbl_pin = pn;
    tick();
    tbl_we = 1'b0;
  endtask

  task automatic expect_fail(input logic [1:0] code, input logic lk);
    sb_q.push_back({code, lk});
  endtask

  // Every auth_fail/card_locked pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && (auth_fail || card_locked)) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_pulse", {29'd0, auth_fail, fail_code}, 32'd0);
      end else begin
        sb_e = sb_q.pop_front();
        chk("sb_fail_pulse", {28'd0, auth_fail, fail_code, card_locked}, {28'd0, 1'b1, sb_e});
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk("rst_prompt", prompt, 0);
    chk("rst_outputs", {auth_ok, auth_fail, card_locked, fail_code, acct_idx}, 0);
    chk("rst_acct_pin", {account_number, pin}, 0);
    rst = 1'b0;
    tick();

    wr(2'd0, 12'h123, 12'h456);
    wr(2'd1, 12'hABC, 12'hDEF);
    wr(2'd2, 12'h123, 12'h111);
    wr(2'd3, 12'h999, 12'h999);

    // happy path
    card();
    chk("hp_acct_entry", prompt, 1);
    keys3(12'h123); key(K_ENTER);
    chk("hp_acct_check", prompt, 2);
    chk("hp_acct_latched", account_number, 12'h123);
    tick();
    chk("hp_pin_entry", prompt, 3);
    chk("hp_idx_lowest", acct_idx, 0);
    keys3(12'h456); key(K_ENTER);
    chk("hp_pin_check", {prompt, auth_ok}, {3'd4, 1'b0});
    tick();
    chk("hp_authed", {prompt, auth_ok}, {3'd5, 1'b1});
    chk("hp_outputs", {account_number, pin, acct_idx}, {12'h123, 12'h456, 2'd0});
    key(5'h1); tick();
    chk("hp_keys_ignored", auth_ok, 1);
    session_end = 1'b1; tick(); session_end = 1'b0;
    chk("hp_end", {prompt, auth_ok}, {3'd0, 1'b0});
    chk("hp_end_clear", {account_number, pin, acct_idx}, 0);

    // lockout
    card(); keys3(12'h123); key(K_ENTER); tick();
    for (int i = 0; i < 3; i++) begin
      expect_fail(2'd2, i == 2);
      keys3(12'h000); key(K_ENTER); tick();
      chk("lk_dest", prompt, (i == 2) ? 0 : 3);
    end
    card(); keys3(12'h123); expect_fail(2'd3, 1'b0); key(K_ENTER); tick();
    chk("lk_locked_idle", prompt, 0);
    wr(2'd0, 12'h123, 12'h456);
    card(); keys3(12'h123); key(K_ENTER); tick();
    chk("lk_unlocked", prompt, 3);
    expect_fail(2'd0, 1'b0); key(K_CANCEL);
    chk("cancel_pin_entry", prompt, 0);

    // unknown account (also proves the write to entry 3 was dropped)
    card(); keys3(12'h999); expect_fail(2'd1, 1'b0); key(K_ENTER); tick();
    chk("unknown_idle", {prompt, fail_code}, {3'd0, 2'd1});

    // entry edits
    card(); key(5'h1); key(5'h2); key(K_ENTER);
    chk("short_enter_ignored", prompt, 1);
    key(5'h7); key(K_CLEAR); key(5'h1); key(5'h2); key(5'h3); key(5'h4); key(K_ENTER);
    chk("edit_latch", {prompt, account_number}, {3'd2, 12'h123});
    tick();

    // timeout: 10 idle cycles in PIN_ENTRY
    expect_fail(2'd0, 1'b0);
    for (int i = 1; i < 10; i++) begin
      tick();
      if (prompt != 3'd3 || auth_fail) chk("tmo_early", {prompt, auth_fail}, {3'd3, 1'b0});
    end
    tick();
    chk("tmo_expire", {prompt, auth_fail, fail_code}, {3'd0, 1'b1, 2'd0});

    // cancel in ACCT_ENTRY
    card(); expect_fail(2'd0, 1'b0); key(K_CANCEL);
    chk("cancel_acct", {prompt, auth_fail, fail_code}, {3'd0, 1'b1, 2'd0});

    // cancel on the expiry cycle -> single pulse
    card();
    for (int i = 0; i < 9; i++) tick();
    expect_fail(2'd0, 1'b0); key(K_CANCEL);
    chk("cancel_tmo_pulse", {prompt, auth_fail}, {3'd0, 1'b1});
    tick();
    chk("cancel_tmo_single", auth_fail, 0);

    // write/check collision: check uses old PIN
    card(); keys3(12'h123); key(K_ENTER); tick();
    keys3(12'h456); key(K_ENTER);
    wr(2'd0, 12'h123, 12'h789);
    chk("coll_authed", {prompt, auth_ok}, {3'd5, 1'b1});
    session_end = 1'b1; tick(); session_end = 1'b0;
    card(); keys3(12'h123); key(K_ENTER); tick();
    expect_fail(2'd2, 1'b0); keys3(12'h456); key(K_ENTER); tick();
    chk("coll_new_pin_live", prompt, 3);
    expect_fail(2'd0, 1'b0); key(K_CANCEL);

    // reset mid-session
    card(); key(5'h1);
    rst = 1'b1; #2;
    chk("rst_mid_async", prompt, 0);
    rst = 1'b0;
    tick();
    chk("rst_mid_quiet", {prompt, auth_fail}, 0);

    tick();
    chk("sb_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
